ddr5_phy_crc_ctrl: RTL and testbench

- Sequences write-CRC generation for one DDR5 device lane group (x4/x8/x16).
- Sits between the write data block and the CRC generation engine.
- Accepts a BL16 write burst as 8 DDR clock beats of 2*pDRAM_SIZE bits each, and drives the engine enable and init.
- Emits the burst plus one appended CRC beat (UI16-17, BL18) as a contiguous stream to the DQ serializer.

---
 rtl/ddr5_phy_crc_ctrl_if.sv | 64 ++++++
 rtl/ddr5_phy_crc_ctrl.sv | 145 ++++++++++++++
 tb/tb_ddr5_phy_crc_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_phy_crc_ctrl_if.sv
// Bundle between write-data block, CRC engine and DQ serializer for ddr5_phy_crc_ctrl.
// crc_err_inj_i is present only when DDR5_PHY_CRC_ERR_INJ_EN is defined.
interface ddr5_phy_crc_ctrl_if #(
  parameter int unsigned pDRAM_SIZE = 4
);
  localparam int unsigned BEAT_W = 2 * pDRAM_SIZE;

  logic              crc_cfg_en_i;
  logic              data_valid_i;
  logic [BEAT_W-1:0] data_i;
  logic              data_ready_o;
  logic              crc_en_o;
  logic              crc_init_o;
  logic [BEAT_W-1:0] crc_data_o;
  logic [BEAT_W-1:0] crc_code_i;
  logic [BEAT_W-1:0] dq_data_o;
  logic              dq_valid_o;
  logic              dq_crc_slot_o;
  logic              busy_o;
  logic              crc_done_o;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
  logic              crc_err_inj_i;
`endif

  // Controller side
  modport slave (
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    input  crc_err_inj_i,
`endif
    input  crc_cfg_en_i,
    input  data_valid_i,
    input  data_i,
    input  crc_code_i,
    output data_ready_o,
    output crc_en_o,
    output crc_init_o,
    output crc_data_o,
    output dq_data_o,
    output dq_valid_o,
    output dq_crc_slot_o,
    output busy_o,
    output crc_done_o
  );

  // Write-data block / engine / serializer side
  modport master (
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    output crc_err_inj_i,
`endif
    output crc_cfg_en_i,
    output data_valid_i,
    output data_i,
    output crc_code_i,
    input  data_ready_o,
    input  crc_en_o,
    input  crc_init_o,
    input  crc_data_o,
    input  dq_data_o,
    input  dq_valid_o,
    input  dq_crc_slot_o,
    input  busy_o,
    input  crc_done_o
  );
endinterface

// File: rtl/ddr5_phy_crc_ctrl.sv
// DDR5 write-CRC sequencer: passes a BL16 burst through and appends the engine's CRC beat.
// Optional CRC error injection enabled by defining DDR5_PHY_CRC_ERR_INJ_EN.
module ddr5_phy_crc_ctrl #(
  parameter int unsigned pDRAM_SIZE  = 4,
  parameter int unsigned pBURST_CLKS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ddr5_phy_crc_ctrl_if.slave  bus
);
  localparam int unsigned BEAT_W = 2 * pDRAM_SIZE;
  localparam int unsigned CNT_W  = (pBURST_CLKS > 1) ? $clog2(pBURST_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(pBURST_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              burst_crc_en_q, burst_crc_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [BEAT_W-1:0] dq_data_q, dq_data_d;
  logic              dq_valid_q, dq_valid_d;
  logic              dq_crc_slot_q, dq_crc_slot_d;
  logic              crc_done_q, crc_done_d;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
  logic              err_arm_q, err_arm_d;
`endif

  logic              accept_c;
  logic              first_beat_c;
  logic              burst_crc_en_c;
  logic              last_beat_c;
  logic              crc_en_c;
  logic [BEAT_W-1:0] crc_beat_c;

  // Handshake decode; the CRC mode for the first beat comes straight from the config input
  always_comb begin
    accept_c       = bus.data_valid_i && ready_q;
    first_beat_c   = (state_q == ST_IDLE);
    burst_crc_en_c = first_beat_c ? bus.crc_cfg_en_i : burst_crc_en_q;
    last_beat_c    = (beat_cnt_q == LAST_BEAT);
    crc_en_c       = accept_c && burst_crc_en_c;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    crc_beat_c     = bus.crc_code_i ^ BEAT_W'(err_arm_q);
`else
    crc_beat_c     = bus.crc_code_i;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    burst_crc_en_d = burst_crc_en_q;
    dq_data_d      = dq_data_q;
    dq_valid_d     = 1'b0;
    dq_crc_slot_d  = 1'b0;
    crc_done_d     = 1'b0;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    err_arm_d      = err_arm_q || bus.crc_err_inj_i;
`endif

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept_c) begin
          burst_crc_en_d = burst_crc_en_c;
          dq_valid_d     = 1'b1;
          dq_data_d      = bus.data_i;
          if (last_beat_c) begin
            beat_cnt_d = '0;
            state_d    = burst_crc_en_c ? ST_CRC : ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            state_d    = ST_DATA;
          end
        end
      end
      ST_CRC: begin
        dq_valid_d    = 1'b1;
        dq_data_d     = crc_beat_c;
        dq_crc_slot_d = 1'b1;
        crc_done_d    = 1'b1;
        state_d       = ST_IDLE;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
        // A pulse landing on the CRC beat re-arms for the following burst
        err_arm_d     = bus.crc_err_inj_i;
`endif
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase

    ready_d = (state_d != ST_CRC);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      burst_crc_en_q <= 1'b0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      dq_data_q      <= '0;
      dq_valid_q     <= 1'b0;
      dq_crc_slot_q  <= 1'b0;
      crc_done_q     <= 1'b0;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
      err_arm_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      burst_crc_en_q <= burst_crc_en_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      dq_data_q      <= dq_data_d;
      dq_valid_q     <= dq_valid_d;
      dq_crc_slot_q  <= dq_crc_slot_d;
      crc_done_q     <= crc_done_d;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
      err_arm_q      <= err_arm_d;
`endif
    end
  end

  // Engine-side signals must be same-cycle with the accepted beat
  assign bus.crc_en_o      = crc_en_c;
  assign bus.crc_init_o    = crc_en_c && first_beat_c;
  assign bus.crc_data_o    = bus.data_i;
  assign bus.data_ready_o  = ready_q;
  assign bus.busy_o        = busy_q;
  assign bus.dq_data_o     = dq_data_q;
  assign bus.dq_valid_o    = dq_valid_q;
  assign bus.dq_crc_slot_o = dq_crc_slot_q;
  assign bus.crc_done_o    = crc_done_q;

endmodule

// File: tb/tb_ddr5_phy_crc_ctrl.sv
// Directed bench for ddr5_phy_crc_ctrl (x4 and x16 instances) with a summing stand-in CRC engine.
module tb_ddr5_phy_crc_ctrl;
  typedef struct {
    logic [31:0] data;
    logic        slot;
    logic        done;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr5_phy_crc_ctrl_if #(.pDRAM_SIZE(4))  bus4 ();
  ddr5_phy_crc_ctrl_if #(.pDRAM_SIZE(16)) bus16 ();

  ddr5_phy_crc_ctrl #(.pDRAM_SIZE(4), .pBURST_CLKS(8)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  ddr5_phy_crc_ctrl #(.pDRAM_SIZE(16), .pBURST_CLKS(8)) u_dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus16)
  );

  // Stand-in engine: CRC = byte/word sum of the burst, registered, seeded by crc_init_o
  logic [7:0]  code4_q  = 8'h00;
  logic [31:0] code16_q = 32'h0;
  always @(posedge clk) begin
    if (bus4.crc_en_o)  code4_q  <= (bus4.crc_init_o  ? 8'h00  : code4_q)  + bus4.crc_data_o;
    if (bus16.crc_en_o) code16_q <= (bus16.crc_init_o ? 32'h0 : code16_q) + bus16.crc_data_o;
  end
  assign bus4.crc_code_i  = code4_q;
  assign bus16.crc_code_i = code16_q;

  // Output monitor: records every valid beat and counts control events
  beat_t      obs4[$];
  beat_t      obs16[$];
  int         en4, init4, nr4, done4, gap4, nr16, done16;
  logic [7:0] init_data4;
  initial begin
    en4 = 0; init4 = 0; nr4 = 0; done4 = 0; gap4 = 0; nr16 = 0; done16 = 0;
    init_data4 = 8'h00;
  end

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (bus4.dq_valid_o) begin
        b.data = 32'(bus4.dq_data_o); b.slot = bus4.dq_crc_slot_o; b.done = bus4.crc_done_o;
        obs4.push_back(b);
      end
      if (bus4.crc_en_o) en4++;
      if (bus4.crc_init_o) begin
        init4++;
        init_data4 = bus4.data_i;
      end
      if (!bus4.data_ready_o) nr4++;
      if (bus4.crc_done_o) done4++;
      if (bus4.busy_o && !bus4.dq_valid_o) gap4++;
      if (bus16.dq_valid_o) begin
        b.data = bus16.dq_data_o; b.slot = bus16.dq_crc_slot_o; b.done = bus16.crc_done_o;
        obs16.push_back(b);
      end
      if (!bus16.data_ready_o) nr16++;
      if (bus16.crc_done_o) done16++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  beat_t exp4[$];
  beat_t exp16[$];

  task automatic push4(input logic [31:0] d, input logic slot);
    beat_t b;
    b.data = d; b.slot = slot; b.done = slot;
    exp4.push_back(b);
  endtask

  task automatic push16(input logic [31:0] d, input logic slot);
    beat_t b;
    b.data = d; b.slot = slot; b.done = slot;
    exp16.push_back(b);
  endtask

  task automatic cmp4(input string tag, input int start);
    check({tag, "_len"}, 64'(obs4.size() - start), 64'(exp4.size()));
    for (int i = 0; i < exp4.size(); i++) begin
      if (start + i < obs4.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(obs4[start+i].data), 64'(exp4[i].data));
        check($sformatf("%s_slot%0d", tag, i), 64'(obs4[start+i].slot), 64'(exp4[i].slot));
        check($sformatf("%s_done%0d", tag, i), 64'(obs4[start+i].done), 64'(exp4[i].done));
      end
    end
    exp4.delete();
  endtask

  task automatic cmp16(input string tag, input int start);
    check({tag, "_len"}, 64'(obs16.size() - start), 64'(exp16.size()));
    for (int i = 0; i < exp16.size(); i++) begin
      if (start + i < obs16.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(obs16[start+i].data), 64'(exp16[i].data));
        check($sformatf("%s_slot%0d", tag, i), 64'(obs16[start+i].slot), 64'(exp16[i].slot));
      end
    end
    exp16.delete();
  endtask

  // Present a beat and hold it (valid high) until the DUT accepts it
  task automatic send4(input logic [7:0] d, input logic cfg);
    logic acc;
    int   guard;
    guard = 0;
    bus4.data_valid_i = 1'b1; bus4.data_i = d; bus4.crc_cfg_en_i = cfg;
    do begin
      @(negedge clk); acc = bus4.data_ready_o;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 10);
    if (!acc) check("x4_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic send16(input logic [31:0] d, input logic cfg);
    logic acc;
    int   guard;
    guard = 0;
    bus16.data_valid_i = 1'b1; bus16.data_i = d; bus16.crc_cfg_en_i = cfg;
    do begin
      @(negedge clk); acc = bus16.data_ready_o;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 10);
    if (!acc) check("x16_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle4(input int n);
    bus4.data_valid_i = 1'b0; bus4.data_i = 8'h00;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [63:0] outs4();
    return 64'({bus4.dq_data_o, bus4.dq_valid_o, bus4.data_ready_o, bus4.busy_o, bus4.crc_en_o,
                bus4.crc_init_o, bus4.crc_done_o, bus4.dq_crc_slot_o});
  endfunction

  function automatic logic [63:0] outs16();
    return 64'({bus16.dq_data_o, bus16.dq_valid_o, bus16.data_ready_o, bus16.busy_o, bus16.crc_en_o,
                bus16.crc_init_o, bus16.crc_done_o, bus16.dq_crc_slot_o, bus16.crc_data_o});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int s, en_s, init_s, nr_s, done_s, gap_s, nr16_s, done16_s;
    rst = 1'b1;
    bus4.data_valid_i  = 1'b0; bus4.data_i  = '0; bus4.crc_cfg_en_i  = 1'b0;
    bus16.data_valid_i = 1'b0; bus16.data_i = '0; bus16.crc_cfg_en_i = 1'b0;
`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    bus4.crc_err_inj_i = 1'b0; bus16.crc_err_inj_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_x4", outs4(), 64'h0);
    check("reset_outs_x16", outs16(), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(bus4.data_ready_o), 64'(1));

    // Basic x4 burst with CRC: sum(01..08) = 0x24
    s = obs4.size(); en_s = en4; init_s = init4; nr_s = nr4; done_s = done4;
    for (int i = 1; i <= 8; i++) push4(32'(i), 1'b0);
    push4(32'h24, 1'b1);
    for (int i = 1; i <= 8; i++) send4(8'(i), 1'b1);
    idle4(4);
    cmp4("basic", s);
    check("basic_en_cycles", 64'(en4 - en_s), 64'(8));
    check("basic_init_count", 64'(init4 - init_s), 64'(1));
    check("basic_init_beat", 64'(init_data4), 64'h01);
    check("basic_ready_low", 64'(nr4 - nr_s), 64'(1));
    check("basic_done_count", 64'(done4 - done_s), 64'(1));

    // CRC disabled, two bursts back-to-back: pure pass-through, no bubble
    s = obs4.size(); en_s = en4; nr_s = nr4; done_s = done4;
    for (int i = 0; i < 16; i++) push4(32'h00A0 + 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) send4(8'hA0 + 8'(i), 1'b0);
    idle4(4);
    cmp4("nocrc", s);
    check("nocrc_en_cycles", 64'(en4 - en_s), 64'(0));
    check("nocrc_ready_low", 64'(nr4 - nr_s), 64'(0));
    check("nocrc_done_count", 64'(done4 - done_s), 64'(0));

    // Stall of 3 cycles after beat 4: sum(31..38) = 0x1A4 -> 0xA4
    s = obs4.size(); en_s = en4; done_s = done4; gap_s = gap4;
    for (int i = 1; i <= 8; i++) push4(32'h30 + 32'(i), 1'b0);
    push4(32'hA4, 1'b1);
    for (int i = 1; i <= 4; i++) send4(8'h30 + 8'(i), 1'b1);
    bus4.data_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", 64'(bus4.dq_data_o), 64'h34);
      @(posedge clk); #1;
    end
    for (int i = 5; i <= 8; i++) send4(8'h30 + 8'(i), 1'b1);
    idle4(4);
    cmp4("stall", s);
    check("stall_gap_cycles", 64'(gap4 - gap_s), 64'(3));
    check("stall_en_cycles", 64'(en4 - en_s), 64'(8));
    check("stall_done_count", 64'(done4 - done_s), 64'(1));

    // Config dropped at beat 3 is ignored: sum(10..17) = 0x9C
    s = obs4.size(); done_s = done4;
    for (int i = 0; i < 8; i++) push4(32'h10 + 32'(i), 1'b0);
    push4(32'h9C, 1'b1);
    for (int i = 0; i < 8; i++) send4(8'h10 + 8'(i), (i < 2) ? 1'b1 : 1'b0);
    idle4(4);
    cmp4("cfgflip", s);
    check("cfgflip_done_count", 64'(done4 - done_s), 64'(1));

    // Asynchronous reset while beat 5 is presented
    s = obs4.size();
    for (int i = 0; i < 4; i++) push4(32'h50 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) send4(8'h50 + 8'(i), 1'b1);
    bus4.data_valid_i = 1'b1; bus4.data_i = 8'h54;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_outs", outs4() >> 0, 64'h0);
    cmp4("midrst", s);
    @(posedge clk); #1;
    bus4.data_valid_i = 1'b0; bus4.data_i = 8'h00;
    rst = 1'b0;
    @(posedge clk); #1;
    // Next burst restarts from beat 0: sum(62..69) = 0x32C -> 0x2C
    s = obs4.size(); init_s = init4; done_s = done4;
    for (int i = 0; i < 8; i++) push4(32'h62 + 32'(i), 1'b0);
    push4(32'h2C, 1'b1);
    for (int i = 0; i < 8; i++) send4(8'h62 + 8'(i), 1'b1);
    idle4(4);
    cmp4("postrst", s);
    check("postrst_init_count", 64'(init4 - init_s), 64'(1));
    check("postrst_init_beat", 64'(init_data4), 64'h62);
    check("postrst_done_count", 64'(done4 - done_s), 64'(1));

`ifdef DDR5_PHY_CRC_ERR_INJ_EN
    // Injection pulse during burst 1 flips bit 0 of that CRC beat only
    s = obs4.size();
    for (int i = 1; i <= 8; i++) push4(32'(i), 1'b0);
    push4(32'h25, 1'b1);
    for (int i = 1; i <= 8; i++) push4(32'(i), 1'b0);
    push4(32'h24, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      bus4.crc_err_inj_i = (i == 2);
      send4(8'(i), 1'b1);
    end
    bus4.crc_err_inj_i = 1'b0;
    for (int i = 1; i <= 8; i++) send4(8'(i), 1'b1);
    idle4(4);
    cmp4("errinj", s);
`endif

    // x16 back-to-back with valid held high: one bubble, two 32-bit CRC beats
    s = obs16.size(); nr16_s = nr16; done16_s = done16;
    for (int i = 1; i <= 8; i++) push16(32'hDEAD_0000 + 32'(i), 1'b0);
    push16(32'hF568_0024, 1'b1);
    for (int i = 1; i <= 8; i++) push16(32'h1234_5600 + 32'(i), 1'b0);
    push16(32'h91A2_B024, 1'b1);
    for (int i = 1; i <= 8; i++) send16(32'hDEAD_0000 + 32'(i), 1'b1);
    for (int i = 1; i <= 8; i++) send16(32'h1234_5600 + 32'(i), 1'b1);
    bus16.data_valid_i = 1'b0; bus16.data_i = '0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    cmp16("x16", s);
    check("x16_ready_low", 64'(nr16 - nr16_s), 64'(2));
    check("x16_done_count", 64'(done16 - done16_s), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
